// File: rtl/bp_be_pkg.sv
// Shared types and address-geometry helpers for the BE stride prefetch generator.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_pf_idle  = 1'b0,
        e_pf_issue = 1'b1
    } bp_be_pf_state_e;

    // Byte-offset bits inside a cache line of block_width bits.
    function automatic int unsigned bp_be_line_offset_width(input int unsigned block_width);
        return $clog2(block_width / 8);
    endfunction

    // Bits that identify the page above the page offset.
    function automatic int unsigned bp_be_page_width(input int unsigned vaddr_width,
                                                     input int unsigned page_offset_width);
        return vaddr_width - page_offset_width;
    endfunction

endpackage

// File: rtl/bp_be_pf_addr_step.sv
// Combinational address step: base + stride, its line-aligned form, and whether it left the page.
module bp_be_pf_addr_step
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned block_width_p       = 512,
    parameter int unsigned page_offset_width_p = 12
) (
    input  logic [vaddr_width_p-1:0]                     base_i,
    input  logic [vaddr_width_p-1:0]                     stride_i,
    input  logic [vaddr_width_p-page_offset_width_p-1:0] page_i,
    output logic [vaddr_width_p-1:0]                     addr_o,
    output logic [vaddr_width_p-1:0]                     line_o,
    output logic                                         cross_o
);

    localparam int unsigned line_off_lp = bp_be_line_offset_width(block_width_p);

    always_comb begin
        addr_o  = base_i + stride_i;
        line_o  = {addr_o[vaddr_width_p-1:line_off_lp], {line_off_lp{1'b0}}};
        cross_o = (addr_o[vaddr_width_p-1:page_offset_width_p] != page_i);
    end

endmodule

// File: rtl/bp_be_stride_prefetch_gen.sv
// Turns confirmed stride events into bursts of line-aligned prefetches, one per valid/ready.
// Optional duplicate-line filter: define BP_BE_PF_LINE_DEDUP_EN.
module bp_be_stride_prefetch_gen
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned stride_width_p      = 8,
    parameter int unsigned pf_degree_p         = 4,
    parameter int unsigned block_width_p       = 512,
    parameter int unsigned page_offset_width_p = 12,
    parameter int unsigned drop_cnt_width_p    = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_discovery_i,
    input  logic                        confirm_discovery_i,
    input  logic [vaddr_width_p-1:0]    striding_pc_i,
    input  logic [vaddr_width_p-1:0]    eff_addr_i,
    input  logic [stride_width_p-1:0]   stride_i,
    input  logic                        flush_i,
    output logic                        pf_v_o,
    output logic [vaddr_width_p-1:0]    pf_addr_o,
    input  logic                        pf_ready_i,
    output logic                        busy_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

    localparam int unsigned page_width_lp = bp_be_page_width(vaddr_width_p, page_offset_width_p);
    localparam int unsigned cnt_width_lp  = $clog2(pf_degree_p + 1);

    bp_be_pf_state_e             state_q, state_d;
    logic [vaddr_width_p-1:0]    pc_q, pc_d;
    logic [vaddr_width_p-1:0]    stride_q, stride_d;
    logic [vaddr_width_p-1:0]    cur_addr_q, cur_addr_d;
    logic [page_width_lp-1:0]    page_q, page_d;
    logic [cnt_width_lp-1:0]     cnt_q, cnt_d;
    logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;
    logic [vaddr_width_p-1:0]    pf_addr_q, pf_addr_d;
    logic                        pf_v_q, pf_v_d;
    logic                        busy_q, busy_d;

    logic [vaddr_width_p-1:0] stride_ext_c;
    logic                     accept_c, hs_c, load_c, advance_c, cur_cross_c, next_cross_c, dup_c;
    logic [vaddr_width_p-1:0] acc_addr_c, acc_line_c, hs_addr_c, hs_line_c;
    logic                     acc_cross_c, hs_cross_c;

    assign stride_ext_c = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign accept_c     = confirm_discovery_i & (|stride_i) & ~flush_i;
    assign hs_c         = pf_v_q & pf_ready_i;
    assign cur_cross_c  = (cur_addr_q[vaddr_width_p-1:page_offset_width_p] != page_q);

    // First address of a freshly accepted stream.
    bp_be_pf_addr_step #(
        .vaddr_width_p      (vaddr_width_p),
        .block_width_p      (block_width_p),
        .page_offset_width_p(page_offset_width_p)
    ) u_acc_step (
        .base_i  (eff_addr_i),
        .stride_i(stride_ext_c),
        .page_i  (eff_addr_i[vaddr_width_p-1:page_offset_width_p]),
        .addr_o  (acc_addr_c),
        .line_o  (acc_line_c),
        .cross_o (acc_cross_c)
    );

    // Address after the current request retires.
    bp_be_pf_addr_step #(
        .vaddr_width_p      (vaddr_width_p),
        .block_width_p      (block_width_p),
        .page_offset_width_p(page_offset_width_p)
    ) u_hs_step (
        .base_i  (cur_addr_q),
        .stride_i(stride_q),
        .page_i  (page_q),
        .addr_o  (hs_addr_c),
        .line_o  (hs_line_c),
        .cross_o (hs_cross_c)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stride_d     = stride_q;
        cur_addr_d   = cur_addr_q;
        page_d       = page_q;
        cnt_d        = cnt_q;
        drop_cnt_d   = drop_cnt_q;
        pf_addr_d    = pf_addr_q;
        load_c       = 1'b0;
        advance_c    = 1'b0;
        next_cross_c = cur_cross_c;

        if (flush_i) begin
            state_d = e_pf_idle;
        end else begin
            unique case (state_q)
                e_pf_idle: load_c = accept_c;
                e_pf_issue: begin
                    if (accept_c && (striding_pc_i == pc_q)) begin
                        load_c = 1'b1;
                    end else begin
                        if (accept_c && !(&drop_cnt_q))
                            drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
                        // In ISSUE with valid low and no page cross means a filtered duplicate.
                        if (cur_cross_c)
                            state_d = e_pf_idle;
                        else if (hs_c || !pf_v_q)
                            advance_c = 1'b1;
                    end
                end
                default: state_d = e_pf_idle;
            endcase
        end

        if (load_c) begin
            state_d      = e_pf_issue;
            pc_d         = striding_pc_i;
            stride_d     = stride_ext_c;
            cur_addr_d   = acc_addr_c;
            page_d       = eff_addr_i[vaddr_width_p-1:page_offset_width_p];
            cnt_d        = cnt_width_lp'(pf_degree_p);
            pf_addr_d    = acc_line_c;
            next_cross_c = acc_cross_c;
        end else if (advance_c) begin
            cur_addr_d   = hs_addr_c;
            cnt_d        = cnt_q - cnt_width_lp'(1);
            pf_addr_d    = hs_line_c;
            next_cross_c = hs_cross_c;
            if (cnt_q == cnt_width_lp'(1))
                state_d = e_pf_idle;
        end

        busy_d = (state_d != e_pf_idle);
    end

    assign pf_v_d = busy_d & ~next_cross_c & ~dup_c;

`ifdef BP_BE_PF_LINE_DEDUP_EN
    logic [vaddr_width_p-1:0] last_line_q, last_line_d;
    logic                     last_v_q, last_v_d;

    always_comb begin
        last_line_d = last_line_q;
        last_v_d    = last_v_q;
        if (hs_c) begin
            last_line_d = pf_addr_q;
            last_v_d    = 1'b1;
        end
        if (flush_i || (start_discovery_i && (striding_pc_i != pc_q)))
            last_v_d = 1'b0;
        dup_c = last_v_d & (pf_addr_d == last_line_d);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_line_q <= '0;
            last_v_q    <= 1'b0;
        end else begin
            last_line_q <= last_line_d;
            last_v_q    <= last_v_d;
        end
    end
`else
    logic unused_start_c;
    assign unused_start_c = start_discovery_i;
    assign dup_c          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_pf_idle;
            pc_q       <= '0;
            stride_q   <= '0;
            cur_addr_q <= '0;
            page_q     <= '0;
            cnt_q      <= '0;
            drop_cnt_q <= '0;
            pf_addr_q  <= '0;
            pf_v_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stride_q   <= stride_d;
            cur_addr_q <= cur_addr_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pf_addr_q  <= pf_addr_d;
            pf_v_q     <= pf_v_d;
            busy_q     <= busy_d;
        end
    end

    assign pf_v_o     = pf_v_q;
    assign pf_addr_o  = pf_addr_q;
    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Directed plus randomized bench for bp_be_stride_prefetch_gen against a stream-level reference model.
module tb_bp_be_stride_prefetch_gen;

    localparam int unsigned V   = 39;
    localparam int unsigned P   = 12;
    localparam int unsigned LO  = 6;
    localparam int unsigned DEG = 4;

    logic         clk, rst_n;
    logic         start_i, confirm_i, flush_i, ready_i;
    logic [V-1:0] pc_i, eff_i;
    logic [7:0]   stride_i;
    logic         pf_v_o, busy_o;
    logic [V-1:0] pf_addr_o;
    logic [7:0]   drop_o;

    bp_be_stride_prefetch_gen #(
        .vaddr_width_p(V), .stride_width_p(8), .pf_degree_p(DEG),
        .block_width_p(512), .page_offset_width_p(P), .drop_cnt_width_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_discovery_i(start_i),
        .confirm_discovery_i(confirm_i), .striding_pc_i(pc_i), .eff_addr_i(eff_i),
        .stride_i(stride_i), .flush_i(flush_i), .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o),
        .pf_ready_i(ready_i), .busy_o(busy_o), .drop_cnt_o(drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one live stream with its remaining request budget.
    bit           m_busy, m_v, m_lv;
    logic [V-1:0] m_cur, m_stride, m_pc, m_addr, m_ll;
    logic [V-P-1:0] m_page;
    int           m_left, m_drop;
    bit           m_hs, m_acc, m_sup;
    logic [V-1:0] m_iss[$];
    logic [V-1:0] d_iss[$];

    function automatic logic [V-1:0] line_of(input logic [V-1:0] a);
        return {a[V-1:LO], 6'b0};
    endfunction

    function automatic bit same_page(input logic [V-1:0] a, input logic [V-P-1:0] pg);
        return a[V-1:P] == pg;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_v = 0; m_lv = 0; m_cur = '0; m_stride = '0; m_pc = '0;
            m_addr = '0; m_ll = '0; m_page = '0; m_left = 0; m_drop = 0;
        end else begin
            m_hs  = m_v && ready_i;
            m_acc = confirm_i && (stride_i != 8'h00) && !flush_i;
`ifdef BP_BE_PF_LINE_DEDUP_EN
            m_sup = m_busy && same_page(m_cur, m_page) && m_lv && (line_of(m_cur) == m_ll);
            if (m_hs) begin m_lv = 1; m_ll = m_addr; end
            if (flush_i || (start_i && pc_i != m_pc)) m_lv = 0;
`else
            m_sup = 0;
`endif
            if (m_hs) m_iss.push_back(m_addr);
            if (flush_i) begin
                m_busy = 0;
            end else if (m_acc && (!m_busy || pc_i == m_pc)) begin
                m_busy   = 1;
                m_pc     = pc_i;
                m_stride = {{(V-8){stride_i[7]}}, stride_i};
                m_cur    = eff_i + m_stride;
                m_page   = eff_i[V-1:P];
                m_left   = DEG;
            end else begin
                if (m_acc && m_drop < 255) m_drop++;
                if (m_busy) begin
                    if (!same_page(m_cur, m_page)) m_busy = 0;
                    else if (m_hs || m_sup) begin
                        m_cur = m_cur + m_stride;
                        m_left--;
                        if (m_left == 0) m_busy = 0;
                    end
                end
            end
            m_addr = line_of(m_cur);
            m_v    = m_busy && same_page(m_cur, m_page)
`ifdef BP_BE_PF_LINE_DEDUP_EN
                     && !(m_lv && line_of(m_cur) == m_ll)
`endif
                     ;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("pf_v", 64'(pf_v_o), 64'(m_v));
            chk("pf_addr", 64'(pf_addr_o), 64'(m_addr));
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("drop_cnt", 64'(drop_o), 64'(m_drop));
        end
    end

    always @(negedge clk) begin
        if (rst_n && pf_v_o && ready_i) d_iss.push_back(pf_addr_o);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        d_iss.delete();
        m_iss.delete();
    endtask

    task automatic confirm(input logic [V-1:0] pc, input logic [V-1:0] eff, input logic [7:0] s);
        confirm_i = 1; pc_i = pc; eff_i = eff; stride_i = s;
    endtask

    task automatic chk_list(input string name, input logic [V-1:0] e[$]);
        chk($sformatf("%s dut count", name), 64'(d_iss.size()), 64'(e.size()));
        chk($sformatf("%s model count", name), 64'(m_iss.size()), 64'(e.size()));
        foreach (e[i]) begin
            if (i < d_iss.size()) chk($sformatf("%s dut[%0d]", name, i), 64'(d_iss[i]), 64'(e[i]));
            if (i < m_iss.size()) chk($sformatf("%s model[%0d]", name, i), 64'(m_iss[i]), 64'(e[i]));
        end
        clr();
    endtask

    localparam logic [V-1:0] PC_A = V'(64'h8000_0100);
    localparam logic [V-1:0] PC_B = V'(64'h8000_0200);

    initial begin
        logic [V-1:0] e[$];
        logic [V-1:0] pcs[3];
        rst_n = 0; start_i = 0; confirm_i = 0; flush_i = 0; ready_i = 0;
        pc_i = '0; eff_i = '0; stride_i = '0;
        tick(2);
        chk("reset pf_v", 64'(pf_v_o), 64'h0);
        chk("reset pf_addr", 64'(pf_addr_o), 64'h0);
        chk("reset busy", 64'(busy_o), 64'h0);
        chk("reset drop", 64'(drop_o), 64'h0);
        rst_n = 1; chk_en = 1;
        tick(2);

        // Basic burst
        clr(); ready_i = 1;
        confirm(PC_A, V'(64'h1000), 8'h40); tick(); confirm_i = 0;
        chk("t1 first pf_v", 64'(pf_v_o), 64'h1);
        chk("t1 first addr", 64'(pf_addr_o), 64'h1040);
        tick(6);
        chk("t1 busy end", 64'(busy_o), 64'h0);
        e.delete(); e.push_back(V'(64'h1040)); e.push_back(V'(64'h1080));
        e.push_back(V'(64'h10C0)); e.push_back(V'(64'h1100));
        chk_list("t1", e);

        // Backpressure
        ready_i = 0;
        confirm(PC_A, V'(64'h1000), 8'h40); tick(); confirm_i = 0;
        tick(3);
        chk("t2 held addr", 64'(pf_addr_o), 64'h1040);
        chk("t2 held v", 64'(pf_v_o), 64'h1);
        ready_i = 1; tick(6);
        chk_list("t2", e);

        // Page cross
        confirm(PC_A, V'(64'h1F80), 8'h40); tick(); confirm_i = 0;
        tick(4);
        chk("t3 busy end", 64'(busy_o), 64'h0);
        e.delete(); e.push_back(V'(64'h1FC0));
        chk_list("t3", e);

        // Negative stride
        confirm(PC_A, V'(64'h2100), 8'hC0); tick(); confirm_i = 0;
        tick(6);
        e.delete(); e.push_back(V'(64'h20C0)); e.push_back(V'(64'h2080));
        e.push_back(V'(64'h2040)); e.push_back(V'(64'h2000));
        chk_list("t4", e);

        // Collision, restart, flush
        ready_i = 0;
        confirm(PC_A, V'(64'h1000), 8'h40); tick();
        confirm(PC_B, V'(64'h5000), 8'h40); tick();
        chk("t5 drop", 64'(drop_o), 64'h1);
        chk("t5 addr kept", 64'(pf_addr_o), 64'h1040);
        confirm(PC_A, V'(64'h3000), 8'h40); tick();
        chk("t5 restart addr", 64'(pf_addr_o), 64'h3040);
        confirm_i = 0; ready_i = 1; tick();
        flush_i = 1; tick();
        chk("t5 flush v", 64'(pf_v_o), 64'h0);
        chk("t5 flush busy", 64'(busy_o), 64'h0);
        flush_i = 0; tick(2); clr();

        // Sub-line stride
        confirm(PC_A, V'(64'h1000), 8'h08); tick(); confirm_i = 0;
        tick(6);
        e.delete();
`ifdef BP_BE_PF_LINE_DEDUP_EN
        e.push_back(V'(64'h1000));
`else
        repeat (4) e.push_back(V'(64'h1000));
`endif
        chk_list("t6", e);

        // Drop counter saturation
        ready_i = 0;
        confirm(PC_A, V'(64'h1000), 8'h40); tick();
        for (int i = 0; i < 300; i++) begin
            confirm(PC_B + V'(i), V'(64'h4000), 8'h10); tick();
        end
        confirm_i = 0;
        chk("drop saturate", 64'(drop_o), 64'hFF);
        flush_i = 1; tick(); flush_i = 0; tick(); clr();

        // Randomized traffic
        pcs[0] = PC_A; pcs[1] = PC_B; pcs[2] = V'(64'h8000_0300);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin rst_n = 0; tick(); rst_n = 1; end
            confirm_i = ($urandom_range(0, 4) == 0);
            start_i   = ($urandom_range(0, 7) == 0);
            pc_i      = pcs[$urandom_range(0, 2)];
            eff_i     = V'($urandom_range(0, 3) << 12) | V'($urandom_range(0, 4095));
            case ($urandom_range(0, 3))
                0: stride_i = 8'h08;
                1: stride_i = 8'hF0;
                default: stride_i = 8'($urandom);
            endcase
            flush_i = ($urandom_range(0, 39) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        confirm_i = 0; flush_i = 0; start_i = 0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
